csr_exec: RTL and testbench

CSR_EXEC -- requirements
Module: csr_exec

---
 rtl/csr_exec.sv | 155 +++++++++++++++
 tb/tb_csr_exec.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exec.sv
// CSR instruction executor: accepts one decoded CSR/ecall/mret request, performs the
// read-modify-write or trap in a single EXEC cycle, then holds the response until taken.
module csr_exec #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_ecall,
  input  logic              in_mret,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CSR_AW-1:0] in_csr_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [4:0]        in_zimm,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_wen,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              trap_ecall,
  output logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rd_data,
  output logic              out_redirect,
  output logic [XLEN-1:0]   out_next_pc,
  output logic              out_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [2:0]          r_op;
  logic                r_ecall;
  logic                r_mret;
  logic [XLEN-1:0]     r_pc;
  logic [CSR_AW-1:0]   r_addr;
  logic [XLEN-1:0]     r_rs1;
  logic [4:0]          r_zimm;

  logic [XLEN-1:0]     r_rdData;
  logic                r_redirect;
  logic [XLEN-1:0]     r_nextPc;
  logic                r_illegal;

  logic                w_accept;
  logic                w_isCsr;
  logic                w_doWrite;
  logic [XLEN-1:0]     w_src;
  logic [XLEN-1:0]     w_newVal;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  // ecall/mret override funct3; op[1:0]==00 covers both illegal encodings 000 and 100
  assign w_isCsr   = !r_ecall && !r_mret && (r_op[1:0] != 2'b00);
  assign w_src     = r_op[2] ? {{(XLEN-5){1'b0}}, r_zimm} : r_rs1;
  assign w_doWrite = w_isCsr && ((r_op[1:0] == 2'b01) || (r_zimm != 5'd0));

  always_comb begin
    w_newVal = w_src;
    case (r_op[1:0])
      2'b10:   w_newVal = csr_rdata | w_src;
      2'b11:   w_newVal = csr_rdata & ~w_src;
      default: w_newVal = w_src;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    csr_raddr   = '0;
    csr_wen     = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    trap_ecall  = 1'b0;
    trap_pc     = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = S_EXEC;
      end
      S_EXEC: begin
        w_nextState = S_RESP;
        csr_raddr   = r_addr;
        csr_wen     = w_doWrite;
        trap_ecall  = r_ecall;
        if (w_doWrite) begin
          csr_waddr = r_addr;
          csr_wdata = w_newVal;
        end
        if (r_ecall) trap_pc = r_pc;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_ecall <= 1'b0;
      r_mret  <= 1'b0;
      r_pc    <= '0;
      r_addr  <= '0;
      r_rs1   <= '0;
      r_zimm  <= '0;
    end else if (w_accept) begin
      r_op    <= in_op;
      r_ecall <= in_ecall;
      r_mret  <= in_mret;
      r_pc    <= in_pc;
      r_addr  <= in_csr_addr;
      r_rs1   <= in_rs1_data;
      r_zimm  <= in_zimm;
    end
  end

  // Response fields are frozen at the end of EXEC so they stay stable through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData   <= '0;
      r_redirect <= 1'b0;
      r_nextPc   <= '0;
      r_illegal  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rdData   <= w_isCsr ? csr_rdata : '0;
      r_redirect <= r_ecall || r_mret;
      r_illegal  <= !r_ecall && !r_mret && !w_isCsr;
      if (r_ecall)     r_nextPc <= csr_mtvec;
      else if (r_mret) r_nextPc <= csr_mepc;
      else             r_nextPc <= r_pc + XLEN'(4);
    end
  end

  assign out_rd_data  = r_rdData;
  assign out_redirect = r_redirect;
  assign out_next_pc  = r_nextPc;
  assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_csr_exec.sv
// Directed testbench for csr_exec: a request-level model predicts every EXEC strobe and
// RESP field, and literal expectations pin the model on the hand-worked cases.
module tb_csr_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic        in_ecall = 1'b0;
  logic        in_mret = 1'b0;
  logic [31:0] in_pc = '0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_rs1_data = '0;
  logic [4:0]  in_zimm = '0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        trap_ecall;
  logic [31:0] trap_pc;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd_data;
  logic        out_redirect;
  logic [31:0] out_next_pc;
  logic        out_illegal;

  logic [31:0] rdataVal = '0;
  logic [31:0] mtvecVal = '0;
  logic [31:0] mepcVal = '0;
  assign csr_rdata = rdataVal;
  assign csr_mtvec = mtvecVal;
  assign csr_mepc  = mepcVal;

  csr_exec #(.XLEN(32), .CSR_AW(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ecall(in_ecall), .in_mret(in_mret),
    .in_pc(in_pc), .in_csr_addr(in_csr_addr), .in_rs1_data(in_rs1_data), .in_zimm(in_zimm),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .trap_ecall(trap_ecall), .trap_pc(trap_pc),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data),
    .out_redirect(out_redirect), .out_next_pc(out_next_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic        ecall;
    logic        mret;
    logic [31:0] pc;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  zimm;
  } req_t;

  typedef struct packed {
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] tpc;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] npc;
    logic        ill;
  } exp_t;

  // What one request must do, given the CSR value and vectors visible while it executes
  function automatic exp_t predict(input req_t r, input logic [31:0] old, input logic [31:0] mtvec,
                                   input logic [31:0] mepc);
    exp_t e;
    logic [31:0] src;
    e = '0;
    src = (r.op inside {3'b101, 3'b110, 3'b111}) ? {27'd0, r.zimm} : r.rs1;
    e.npc = r.pc + 32'd4;
    if (r.ecall) begin
      e.trap = 1'b1; e.tpc = r.pc; e.redir = 1'b1; e.npc = mtvec;
    end else if (r.mret) begin
      e.redir = 1'b1; e.npc = mepc;
    end else begin
      case (r.op)
        3'b001, 3'b101: begin e.wen = 1'b1;             e.wdata = src;        e.rd = old; end
        3'b010, 3'b110: begin e.wen = (r.zimm != 5'd0); e.wdata = old | src;  e.rd = old; end
        3'b011, 3'b111: begin e.wen = (r.zimm != 5'd0); e.wdata = old & ~src; e.rd = old; end
        default:        e.ill = 1'b1;
      endcase
    end
    if (e.wen) e.waddr = r.addr;
    return e;
  endfunction

  bit          mBusy = 1'b0;
  int          mAge = 0;
  req_t        mReq = '0;
  exp_t        mExp = '0;
  int          wenCycles = 0;
  int          trapCycles = 0;
  logic [31:0] lastWdata = '0;
  logic [31:0] lastTrapPc = '0;

  // Request tracker: age 0 is the cycle after acceptance, age >= 1 is the response phase
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy = 1'b0;
      mAge  = 0;
    end else if (mBusy) begin
      if (mAge >= 1 && out_ready) mBusy = 1'b0;
      else mAge++;
    end else if (in_valid) begin
      mBusy = 1'b1;
      mAge  = 0;
      mReq  = '{in_op, in_ecall, in_mret, in_pc, in_csr_addr, in_rs1_data, in_zimm};
      wenCycles  = 0;
      trapCycles = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst.csr_wen", 32'(csr_wen), 32'd0);
      checkOutput("rst.trap_ecall", 32'(trap_ecall), 32'd0);
      checkOutput("rst.csr_raddr", 32'(csr_raddr), 32'd0);
      checkOutput("rst.out_rd_data", out_rd_data, 32'd0);
      checkOutput("rst.out_redirect", 32'(out_redirect), 32'd0);
      checkOutput("rst.out_next_pc", out_next_pc, 32'd0);
      checkOutput("rst.out_illegal", 32'(out_illegal), 32'd0);
    end else begin
      if (csr_wen) begin wenCycles++; lastWdata = csr_wdata; end
      if (trap_ecall) begin trapCycles++; lastTrapPc = trap_pc; end
      if (!mBusy) begin
        checkOutput("idle.in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle.out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle.csr_wen", 32'(csr_wen), 32'd0);
        checkOutput("idle.trap_ecall", 32'(trap_ecall), 32'd0);
      end else if (mAge == 0) begin
        mExp = predict(mReq, rdataVal, mtvecVal, mepcVal);
        checkOutput("exec.in_ready", 32'(in_ready), 32'd0);
        checkOutput("exec.out_valid", 32'(out_valid), 32'd0);
        checkOutput("exec.csr_raddr", 32'(csr_raddr), 32'(mReq.addr));
        checkOutput("exec.csr_wen", 32'(csr_wen), 32'(mExp.wen));
        checkOutput("exec.trap_ecall", 32'(trap_ecall), 32'(mExp.trap));
        if (mExp.wen) begin
          checkOutput("exec.csr_waddr", 32'(csr_waddr), 32'(mExp.waddr));
          checkOutput("exec.csr_wdata", csr_wdata, mExp.wdata);
        end
        if (mExp.trap) checkOutput("exec.trap_pc", trap_pc, mExp.tpc);
      end else begin
        checkOutput("resp.in_ready", 32'(in_ready), 32'd0);
        checkOutput("resp.out_valid", 32'(out_valid), 32'd1);
        checkOutput("resp.csr_wen", 32'(csr_wen), 32'd0);
        checkOutput("resp.trap_ecall", 32'(trap_ecall), 32'd0);
        checkOutput("resp.out_rd_data", out_rd_data, mExp.rd);
        checkOutput("resp.out_redirect", 32'(out_redirect), 32'(mExp.redir));
        checkOutput("resp.out_next_pc", out_next_pc, mExp.npc);
        checkOutput("resp.out_illegal", 32'(out_illegal), 32'(mExp.ill));
      end
    end
  end

  logic [31:0] rdObs, npcObs, redirObs, illObs;

  task automatic applyStimulus(input logic [2:0] op, input logic ecall, input logic mret,
                               input logic [31:0] pc, input logic [11:0] addr, input logic [31:0] rs1,
                               input logic [4:0] zimm, input logic [31:0] old,
                               input logic [31:0] mtvec, input logic [31:0] mepc);
    int n = 0;
    in_op = op; in_ecall = ecall; in_mret = mret; in_pc = pc;
    in_csr_addr = addr; in_rs1_data = rs1; in_zimm = zimm;
    rdataVal = old; mtvecVal = mtvec; mepcVal = mepc;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResp(input int holdCycles);
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin
      checks++;
      $display("[TB] FAIL resp_timeout: out_valid stayed 0 for %0d cycles, expected 1", n);
    end
    repeat (holdCycles) begin @(posedge clk); #1; end
    rdObs = out_rd_data; npcObs = out_next_pc;
    redirObs = 32'(out_redirect); illObs = 32'(out_illegal);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // CSRRW mtvec
    applyStimulus(3'b001, 0, 0, 32'h8000_0000, 12'h305, 32'h8000_0000, 5'd1, 32'h1234, 0, 0);
    waitResp(0);
    checkOutput("rw.wen_cycles", 32'(wenCycles), 32'd1);
    checkOutput("rw.wdata", lastWdata, 32'h8000_0000);
    checkOutput("rw.rd", rdObs, 32'h1234);
    checkOutput("rw.next_pc", npcObs, 32'h8000_0004);

    // CSRRS with rs1=x0 reads without writing
    applyStimulus(3'b010, 0, 0, 32'h8000_0004, 12'h300, 32'hDEAD_BEEF, 5'd0, 32'h1800, 0, 0);
    waitResp(0);
    checkOutput("rs0.wen_cycles", 32'(wenCycles), 32'd0);
    checkOutput("rs0.rd", rdObs, 32'h1800);

    applyStimulus(3'b111, 0, 0, 32'h8000_0008, 12'h344, 32'h0, 5'd3, 32'hF, 0, 0);
    waitResp(1);
    checkOutput("rci.wdata", lastWdata, 32'hC);
    checkOutput("rci.rd", rdObs, 32'hF);

    applyStimulus(3'b110, 0, 0, 32'h8000_000C, 12'h304, 32'h0, 5'd5, 32'h8, 0, 0);
    waitResp(0);
    checkOutput("rsi.wdata", lastWdata, 32'hD);

    // ecall
    applyStimulus(3'b000, 1, 0, 32'h8000_0010, 12'h000, 32'h0, 5'd0, 32'h55, 32'h8000_0100, 32'h0);
    waitResp(0);
    checkOutput("ecall.trap_cycles", 32'(trapCycles), 32'd1);
    checkOutput("ecall.trap_pc", lastTrapPc, 32'h8000_0010);
    checkOutput("ecall.wen_cycles", 32'(wenCycles), 32'd0);
    checkOutput("ecall.redirect", redirObs, 32'd1);
    checkOutput("ecall.next_pc", npcObs, 32'h8000_0100);
    checkOutput("ecall.rd", rdObs, 32'd0);

    // mret with a CSR op encoded alongside: op is ignored
    applyStimulus(3'b001, 0, 1, 32'h8000_0100, 12'h341, 32'h1, 5'd1, 32'h77, 32'h8000_0100, 32'h8000_0014);
    waitResp(0);
    checkOutput("mret.wen_cycles", 32'(wenCycles), 32'd0);
    checkOutput("mret.trap_cycles", 32'(trapCycles), 32'd0);
    checkOutput("mret.next_pc", npcObs, 32'h8000_0014);

    applyStimulus(3'b010, 1, 1, 32'h8000_0020, 12'h300, 32'h1, 5'd1, 32'h0, 32'h8000_0100, 32'h8000_0014);
    waitResp(0);
    checkOutput("both.trap_cycles", 32'(trapCycles), 32'd1);
    checkOutput("both.next_pc", npcObs, 32'h8000_0100);

    // CSRRC with back-pressure held for five cycles
    applyStimulus(3'b011, 0, 0, 32'h8000_0024, 12'h340, 32'h0F0F, 5'd7, 32'hFFFF, 0, 0);
    waitResp(5);
    checkOutput("rc.wdata", lastWdata, 32'hF0F0);
    checkOutput("rc.rd_after_hold", rdObs, 32'hFFFF);
    checkOutput("rc.next_pc_after_hold", npcObs, 32'h8000_0028);

    applyStimulus(3'b101, 0, 0, 32'hFFFF_FFFC, 12'h340, 32'h0, 5'h1F, 32'h3, 0, 0);
    waitResp(0);
    checkOutput("wrap.next_pc", npcObs, 32'h0);
    checkOutput("wrap.wdata", lastWdata, 32'h1F);

    applyStimulus(3'b100, 0, 0, 32'h8000_0030, 12'h300, 32'hFF, 5'd9, 32'h99, 0, 0);
    waitResp(0);
    checkOutput("ill.illegal", illObs, 32'd1);
    checkOutput("ill.wen_cycles", 32'(wenCycles), 32'd0);
    checkOutput("ill.redirect", redirObs, 32'd0);
    checkOutput("ill.next_pc", npcObs, 32'h8000_0034);

    // Reset arriving mid-EXEC must kill the write strobe immediately
    applyStimulus(3'b001, 0, 0, 32'h8000_0040, 12'h305, 32'hAAAA, 5'd2, 32'h1, 0, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstexec.csr_wen", 32'(csr_wen), 32'd0);
    checkOutput("rstexec.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstexit.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(3'b001, 0, 0, 32'h8000_0050, 12'h305, 32'h4321, 5'd2, 32'h9, 0, 0);
    waitResp(0);
    checkOutput("rstexit.wdata", lastWdata, 32'h4321);
    checkOutput("rstexit.rd", rdObs, 32'h9);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded 100000 time units, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
